// File: rtl/coincid_trg_gen_pkg.sv
// Shared definitions for the coincidence trigger generator.
// Contents: the FSM state encoding and the default parameter values that the
// top module and the interface both use.
package coincid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MATCH = 2'd1,
        ST_TRIG  = 2'd2,
        ST_DEAD  = 2'd3
    } state_e;

    localparam int NUM_HIT_DEF       = 8;
    localparam int NUM_BUSY_DEF      = 2;
    localparam int NUM_GRP_DEF       = 5;
    localparam int ALIGN_W_DEF       = 4;
    localparam int DIV_W_DEF         = 6;
    localparam int CNT_W_DEF         = 16;
    localparam int DEAD_W_DEF        = 24;
    localparam int DEAD_TIME_NUM_DEF = 15000;

endpackage

// File: rtl/coincid_trg_gen_if.sv
// Signal bundle of the coincidence trigger generator.
// master : hit/busy lines and configuration driven in, trigger results read back
// slave  : the trigger generator side
// Hit/busy lines are active low; everything else is active high.
interface coincid_trg_gen_if
    import coincid_pkg::*;
#(
    parameter int NUM_HIT  = NUM_HIT_DEF,
    parameter int NUM_BUSY = NUM_BUSY_DEF,
    parameter int NUM_GRP  = NUM_GRP_DEF,
    parameter int ALIGN_W  = ALIGN_W_DEF,
    parameter int DIV_W    = DIV_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) ();
    logic [NUM_HIT-1:0]          hit_a_in_N;
    logic [NUM_HIT-1:0]          hit_b_in_N;
    logic [NUM_HIT-1:0]          hit_ab_sel_in;
    logic [NUM_HIT-1:0]          hit_mask_in;
    logic [NUM_BUSY-1:0]         busy_a_in_N;
    logic [NUM_BUSY-1:0]         busy_b_in_N;
    logic [NUM_BUSY-1:0]         busy_ab_sel_in;
    logic [NUM_BUSY-1:0]         busy_mask_in;
    logic [NUM_HIT*ALIGN_W-1:0]  hit_align_in;
    logic [NUM_GRP*NUM_HIT-1:0]  grp_pattern_in;
    logic [NUM_GRP-1:0]          grp_oe_in;
    logic [NUM_GRP*DIV_W-1:0]    grp_div_in;
    logic [7:0]                  trg_match_win_in;
    logic                        coincid_trg_out;
    logic [NUM_GRP-1:0]          coincid_tag_out;
    logic                        dead_out;
    logic [NUM_HIT-1:0]          hit_syn_out;
    logic [NUM_BUSY-1:0]         busy_syn_out;
    logic [NUM_GRP*CNT_W-1:0]    coincid_grp_cnt_out;

    modport master (
        output hit_a_in_N, hit_b_in_N, hit_ab_sel_in, hit_mask_in,
        output busy_a_in_N, busy_b_in_N, busy_ab_sel_in, busy_mask_in,
        output hit_align_in, grp_pattern_in, grp_oe_in, grp_div_in, trg_match_win_in,
        input  coincid_trg_out, coincid_tag_out, dead_out,
        input  hit_syn_out, busy_syn_out, coincid_grp_cnt_out
    );

    modport slave (
        input  hit_a_in_N, hit_b_in_N, hit_ab_sel_in, hit_mask_in,
        input  busy_a_in_N, busy_b_in_N, busy_ab_sel_in, busy_mask_in,
        input  hit_align_in, grp_pattern_in, grp_oe_in, grp_div_in, trg_match_win_in,
        output coincid_trg_out, coincid_tag_out, dead_out,
        output hit_syn_out, busy_syn_out, coincid_grp_cnt_out
    );
endinterface

// File: rtl/coincid_trg_gen_hit_conditioner.sv
// Conditioning of one hit channel: 2-FF synchroniser on both redundant sides,
// inversion to active high, A/B select, mask, rising-edge detect and stretch.
// Ports: clk_in, rst_in_N, hit_a_in_N/hit_b_in_N (active-low lines),
//        ab_sel_in (0=A, 1=B), mask_in (1=forced inactive),
//        align_in (stretch length, 0 treated as 1), hit_syn_out (stretched level).
module hit_conditioner #(
    parameter int ALIGN_W = 4
) (
    input  logic               clk_in,
    input  logic               rst_in_N,
    input  logic               hit_a_in_N,
    input  logic               hit_b_in_N,
    input  logic               ab_sel_in,
    input  logic               mask_in,
    input  logic [ALIGN_W-1:0] align_in,
    output logic               hit_syn_out
);
    // Inverted before the synchroniser so the cleared state means "no hit".
    logic [1:0]         sync_a_q, sync_b_q;
    logic               lvl, lvl_prev_q;
    logic [ALIGN_W-1:0] stretch_q, stretch_d;

    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            sync_a_q   <= '0;
            sync_b_q   <= '0;
            lvl_prev_q <= 1'b0;
            stretch_q  <= '0;
        end else begin
            sync_a_q   <= {sync_a_q[0], ~hit_a_in_N};
            sync_b_q   <= {sync_b_q[0], ~hit_b_in_N};
            lvl_prev_q <= lvl;
            stretch_q  <= stretch_d;
        end
    end

    assign lvl = (ab_sel_in ? sync_b_q[1] : sync_a_q[1]) & ~mask_in;

    // A new rising edge restarts the stretch even if one is still running.
    always_comb begin
        stretch_d = stretch_q;
        if (lvl && !lvl_prev_q) begin
            stretch_d = (align_in == '0) ? ALIGN_W'(1) : align_in;
        end else if (stretch_q != '0) begin
            stretch_d = stretch_q - ALIGN_W'(1);
        end
    end

    assign hit_syn_out = (stretch_q != '0);
endmodule

// File: rtl/coincid_trg_gen.sv
// Coincidence trigger generator: conditions hit/busy lines, opens a match
// window on the first hit, tags logic groups whose pattern is fully present,
// prescales them and emits a one-cycle trigger followed by a dead time.
// Ports: clk_in, rst_in_N (async active low), bus (coincid_trg_gen_if.slave).
// Build option: define COINCID_TRG_CNT_EN to include the per-group raw
// match counters; otherwise coincid_grp_cnt_out is tied to zero.
//
//  state | meaning
//  IDLE  | waiting for a hit while no busy line is active
//  MATCH | window open, matching groups accumulate into the tag register
//  TRIG  | one-cycle trigger pulse, fired groups latched on the tag output
//  DEAD  | dead time running; leaves once expired and busy is clear
module coincid_trg_gen
    import coincid_pkg::*;
#(
    parameter int NUM_HIT       = NUM_HIT_DEF,
    parameter int NUM_BUSY      = NUM_BUSY_DEF,
    parameter int NUM_GRP       = NUM_GRP_DEF,
    parameter int ALIGN_W       = ALIGN_W_DEF,
    parameter int DIV_W         = DIV_W_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int DEAD_W        = DEAD_W_DEF,
    parameter int DEAD_TIME_NUM = DEAD_TIME_NUM_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in_N,
    coincid_trg_gen_if.slave bus
);
    state_e              state_q, state_d;
    logic [NUM_HIT-1:0]  hit_syn;
    logic [NUM_BUSY-1:0] busy_a_s1_q, busy_a_s2_q, busy_b_s1_q, busy_b_s2_q, busy_syn;
    logic                busy_any;
    logic [NUM_GRP-1:0]  match, tag_all, fire, tag_q, tag_d, tag_out_q, tag_out_d;
    logic [7:0]          win_q, win_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic [DIV_W-1:0]    presc_q [NUM_GRP];
    logic [DIV_W-1:0]    presc_d [NUM_GRP];
    logic [DIV_W-1:0]    div_eff, presc_inc;
    logic [NUM_HIT-1:0]  pat;
    logic                win_end, trg_pulse, dead_flag;

    for (genvar h = 0; h < NUM_HIT; h++) begin : g_hit
        hit_conditioner #(.ALIGN_W(ALIGN_W)) u_cond (
            .clk_in      (clk_in),
            .rst_in_N    (rst_in_N),
            .hit_a_in_N  (bus.hit_a_in_N[h]),
            .hit_b_in_N  (bus.hit_b_in_N[h]),
            .ab_sel_in   (bus.hit_ab_sel_in[h]),
            .mask_in     (bus.hit_mask_in[h]),
            .align_in    (bus.hit_align_in[h*ALIGN_W +: ALIGN_W]),
            .hit_syn_out (hit_syn[h])
        );
    end

    assign busy_syn = ((bus.busy_ab_sel_in & busy_b_s2_q) | (~bus.busy_ab_sel_in & busy_a_s2_q))
                      & ~bus.busy_mask_in;
    assign busy_any = |busy_syn;

    always_comb begin
        match = '0;
        pat   = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            pat      = bus.grp_pattern_in[g*NUM_HIT +: NUM_HIT];
            match[g] = bus.grp_oe_in[g] && (pat != '0) && ((hit_syn & pat) == pat);
        end
    end

    // The final window cycle still contributes its matches to the decision.
    assign tag_all = tag_q | match;
    assign win_end = (state_q == ST_MATCH) && (win_q <= 8'd1);

    // ">=" rather than "==" so that lowering a divisor live cannot strand a count.
    always_comb begin
        fire      = '0;
        div_eff   = '0;
        presc_inc = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            presc_d[g] = presc_q[g];
            div_eff    = bus.grp_div_in[g*DIV_W +: DIV_W];
            if (div_eff == '0) div_eff = DIV_W'(1);
            presc_inc  = presc_q[g] + DIV_W'(1);
            if (win_end && tag_all[g]) begin
                if (presc_inc >= div_eff) begin
                    fire[g]    = 1'b1;
                    presc_d[g] = '0;
                end else begin
                    presc_d[g] = presc_inc;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!busy_any && (hit_syn != '0)) state_d = ST_MATCH;
            ST_MATCH: if (win_end) state_d = (fire != '0) ? ST_TRIG : ST_IDLE;
            ST_TRIG:  state_d = ST_DEAD;
            ST_DEAD:  if ((dead_q == '0) && !busy_any) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        trg_pulse = (state_q == ST_TRIG);
        dead_flag = (state_q == ST_DEAD);
    end

    // The dead counter is loaded as TRIG begins and already counts during TRIG,
    // so DEAD lasts exactly DEAD_TIME_NUM cycles when no busy line is active.
    always_comb begin
        win_d     = win_q;
        tag_d     = tag_q;
        tag_out_d = tag_out_q;
        dead_d    = dead_q;
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_MATCH) begin
                    win_d = (bus.trg_match_win_in == 8'd0) ? 8'd1 : bus.trg_match_win_in;
                    tag_d = match;
                end
            end
            ST_MATCH: begin
                win_d = win_q - 8'd1;
                tag_d = tag_all;
                if (win_end) begin
                    tag_d = '0;
                    if (fire != '0) begin
                        tag_out_d = fire;
                        dead_d    = DEAD_W'(DEAD_TIME_NUM);
                    end
                end
            end
            default: if (dead_q != '0) dead_d = dead_q - DEAD_W'(1);
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            busy_a_s1_q <= '0;
            busy_a_s2_q <= '0;
            busy_b_s1_q <= '0;
            busy_b_s2_q <= '0;
            win_q       <= '0;
            tag_q       <= '0;
            tag_out_q   <= '0;
            dead_q      <= '0;
            for (int g = 0; g < NUM_GRP; g++) presc_q[g] <= '0;
        end else begin
            busy_a_s1_q <= ~bus.busy_a_in_N;
            busy_a_s2_q <= busy_a_s1_q;
            busy_b_s1_q <= ~bus.busy_b_in_N;
            busy_b_s2_q <= busy_b_s1_q;
            win_q       <= win_d;
            tag_q       <= tag_d;
            tag_out_q   <= tag_out_d;
            dead_q      <= dead_d;
            for (int g = 0; g < NUM_GRP; g++) presc_q[g] <= presc_d[g];
        end
    end

`ifdef COINCID_TRG_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_GRP];

    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            for (int g = 0; g < NUM_GRP; g++) cnt_q[g] <= '0;
        end else begin
            for (int g = 0; g < NUM_GRP; g++) begin
                if (win_end && tag_all[g] && (cnt_q[g] != '1)) cnt_q[g] <= cnt_q[g] + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_cnt
        assign bus.coincid_grp_cnt_out[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`else
    assign bus.coincid_grp_cnt_out = '0;
`endif

    assign bus.coincid_trg_out = trg_pulse;
    assign bus.dead_out        = dead_flag;
    assign bus.coincid_tag_out = tag_out_q;
    assign bus.hit_syn_out     = hit_syn;
    assign bus.busy_syn_out    = busy_syn;
endmodule

// File: tb/tb_coincid_trg_gen.sv
module tb_coincid_trg_gen;
    localparam int CNT_ON =
`ifdef COINCID_TRG_CNT_EN
        1;
`else
        0;
`endif

    logic clk_in   = 1'b0;
    logic rst_in_N = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   trg_count = 0;
    int   base;

    always #5 clk_in = ~clk_in;

    coincid_trg_gen_if #(.NUM_HIT(8), .NUM_BUSY(2), .NUM_GRP(5), .ALIGN_W(4),
                         .DIV_W(6), .CNT_W(16)) bus ();

    coincid_trg_gen dut (
        .clk_in   (clk_in),
        .rst_in_N (rst_in_N),
        .bus      (bus)
    );

    always @(posedge clk_in) if (bus.coincid_trg_out === 1'b1) trg_count++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drive the selected lines low at cycle 0, release after 3 cycles, stop at cycle n.
    task automatic run_event(input logic [7:0] a_on, input logic [7:0] b_on, input int n);
        bus.hit_a_in_N = ~a_on;
        bus.hit_b_in_N = ~b_on;
        repeat (3) tick();
        bus.hit_a_in_N = 8'hFF;
        bus.hit_b_in_N = 8'hFF;
        repeat (n - 3) tick();
    endtask

    task automatic wait_dead_low(input string tag);
        for (int i = 0; i < 16000 && bus.dead_out !== 1'b0; i++) tick();
        chk(tag, 64'(bus.dead_out), 64'd0);
    endtask

    initial begin
        bus.hit_a_in_N       = 8'hFF;
        bus.hit_b_in_N       = 8'hFF;
        bus.hit_ab_sel_in    = 8'h00;
        bus.hit_mask_in      = 8'h00;
        bus.busy_a_in_N      = 2'b11;
        bus.busy_b_in_N      = 2'b11;
        bus.busy_ab_sel_in   = 2'b00;
        bus.busy_mask_in     = 2'b00;
        bus.hit_align_in     = {8{4'd4}};
        bus.grp_pattern_in   = {8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
        bus.grp_oe_in        = 5'b00001;
        bus.grp_div_in       = {5{6'd1}};
        bus.trg_match_win_in = 8'd20;

        // reset state
        repeat (3) tick();
        chk("rst_trg",  64'(bus.coincid_trg_out), 64'd0);
        chk("rst_tag",  64'(bus.coincid_tag_out), 64'd0);
        chk("rst_dead", 64'(bus.dead_out), 64'd0);
        chk("rst_hit",  64'(bus.hit_syn_out), 64'd0);
        chk("rst_busy", 64'(bus.busy_syn_out), 64'd0);
        chk("rst_cnt",  64'(bus.coincid_grp_cnt_out[63:0]), 64'd0);
        rst_in_N = 1'b1;
        repeat (2) tick();

        // basic coincidence ch0+ch1, window 20, align 4
        bus.hit_a_in_N = 8'hFC;
        tick(); tick();
        chk("syn_c2", 64'(bus.hit_syn_out), 64'h00);
        tick();
        chk("syn_c3", 64'(bus.hit_syn_out), 64'h03);
        bus.hit_a_in_N = 8'hFF;
        repeat (3) tick();
        chk("syn_c6", 64'(bus.hit_syn_out), 64'h03);
        tick();
        chk("syn_c7", 64'(bus.hit_syn_out), 64'h00);
        repeat (16) tick();
        chk("trg_c23", 64'(bus.coincid_trg_out), 64'd0);
        tick();
        chk("trg_c24", 64'(bus.coincid_trg_out), 64'd1);
        chk("tag_c24", 64'(bus.coincid_tag_out), 64'h01);
        chk("cnt_c24", 64'(bus.coincid_grp_cnt_out[15:0]), 64'(CNT_ON));
        tick();
        chk("trg_c25",  64'(bus.coincid_trg_out), 64'd0);
        chk("dead_c25", 64'(bus.dead_out), 64'd1);
        repeat (14999) tick();
        chk("dead_last", 64'(bus.dead_out), 64'd1);
        tick();
        chk("dead_end", 64'(bus.dead_out), 64'd0);

        // prescale by 2 over four events, busy held across the last dead time
        rst_in_N = 1'b0;
        tick();
        rst_in_N = 1'b1;
        tick();
        chk("presc_cnt0", 64'(bus.coincid_grp_cnt_out[15:0]), 64'd0);
        bus.grp_div_in = {6'd1, 6'd1, 6'd1, 6'd1, 6'd2};
        base = trg_count;
        run_event(8'h03, 8'h00, 40);
        chk("presc_ev1", 64'(trg_count - base), 64'd0);
        chk("presc_ev1_dead", 64'(bus.dead_out), 64'd0);
        run_event(8'h03, 8'h00, 24);
        chk("presc_ev2_trg", 64'(bus.coincid_trg_out), 64'd1);
        tick();
        wait_dead_low("presc_ev2_dead");
        run_event(8'h03, 8'h00, 40);
        chk("presc_ev3", 64'(trg_count - base), 64'd1);
        chk("presc_tag_hold", 64'(bus.coincid_tag_out), 64'h01);
        run_event(8'h03, 8'h00, 24);
        chk("presc_ev4_trg", 64'(bus.coincid_trg_out), 64'd1);
        tick();
        bus.busy_a_in_N = 2'b10;
        tick(); tick();
        chk("busy_syn_on", 64'(bus.busy_syn_out), 64'h1);
        repeat (15073) tick();
        chk("busy_hold_dead", 64'(bus.dead_out), 64'd1);
        bus.busy_a_in_N = 2'b11;
        tick();
        chk("busy_rel1_syn",  64'(bus.busy_syn_out), 64'h1);
        chk("busy_rel1_dead", 64'(bus.dead_out), 64'd1);
        tick();
        chk("busy_rel2_syn",  64'(bus.busy_syn_out), 64'h0);
        chk("busy_rel2_dead", 64'(bus.dead_out), 64'd1);
        tick();
        chk("busy_rel3_dead", 64'(bus.dead_out), 64'd0);
        chk("presc_trg_total", 64'(trg_count - base), 64'd2);
        chk("presc_cnt4", 64'(bus.coincid_grp_cnt_out[15:0]), 64'(4 * CNT_ON));

        // ch1 masked: nothing fires
        bus.grp_div_in  = {5{6'd1}};
        bus.hit_mask_in = 8'h02;
        base = trg_count;
        bus.hit_a_in_N = 8'hFC;
        repeat (3) tick();
        chk("mask_syn", 64'(bus.hit_syn_out), 64'h01);
        bus.hit_a_in_N = 8'hFF;
        repeat (37) tick();
        chk("mask_trg", 64'(trg_count - base), 64'd0);
        chk("mask_dead", 64'(bus.dead_out), 64'd0);
        chk("mask_cnt", 64'(bus.coincid_grp_cnt_out[15:0]), 64'(4 * CNT_ON));

        // ch1 from B side, several groups, reset aborting a window
        bus.hit_mask_in    = 8'h00;
        bus.hit_ab_sel_in  = 8'h02;
        bus.grp_oe_in      = 5'b01111;
        bus.grp_pattern_in = {8'h00, 8'h00, 8'h04, 8'h01, 8'h03};
        base = trg_count;
        run_event(8'h01, 8'h02, 10);
        rst_in_N = 1'b0;
        #1;
        chk("arst_trg",  64'(bus.coincid_trg_out), 64'd0);
        chk("arst_tag",  64'(bus.coincid_tag_out), 64'd0);
        chk("arst_dead", 64'(bus.dead_out), 64'd0);
        chk("arst_hit",  64'(bus.hit_syn_out), 64'd0);
        chk("arst_cnt",  64'(bus.coincid_grp_cnt_out[63:0]), 64'd0);
        tick();
        rst_in_N = 1'b1;
        repeat (30) tick();
        chk("arst_no_trg", 64'(trg_count - base), 64'd0);
        chk("arst_idle_dead", 64'(bus.dead_out), 64'd0);
        run_event(8'h01, 8'h02, 24);
        chk("bsel_trg", 64'(bus.coincid_trg_out), 64'd1);
        chk("bsel_tag", 64'(bus.coincid_tag_out), 64'h03);
        tick();
        chk("bsel_dead", 64'(bus.dead_out), 64'd1);
        chk("bsel_cnt", 64'(bus.coincid_grp_cnt_out[63:0]),
            (CNT_ON != 0) ? 64'h0000_0000_0001_0001 : 64'd0);
        chk("bsel_trg_total", 64'(trg_count - base), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/coincid_trg_gen.md
COINCID_TRG_GEN -- requirements
Module: coincid_trg_gen

Interface
REQ-001 Parameter NUM_HIT, default 8, number of hit channels.
REQ-002 Parameter NUM_BUSY, default 2, number of busy channels.
REQ-003 Parameter NUM_GRP, default 5, number of logic groups (trigger types).
REQ-004 Parameters ALIGN_W, DIV_W, CNT_W, DEAD_W, defaults 4, 6, 16, 24: widths of align, prescale divisor, counter and dead-time fields.
REQ-005 Parameter DEAD_TIME_NUM, default 15000, dead-time length in clk_in cycles.
REQ-006 Ports: clk_in  in  1  single system clock; rst_in_N  in  1  asynchronous active-low reset.
REQ-007 Ports: hit_a_in_N, hit_b_in_N  in  NUM_HIT  active-low hit lines, A and B redundant sides.
REQ-008 Ports: hit_ab_sel_in (0=A, 1=B), hit_mask_in (1=forced inactive)  in  NUM_HIT.
REQ-009 Ports: busy_a_in_N, busy_b_in_N, busy_ab_sel_in, busy_mask_in  in  NUM_BUSY  same semantics as hit ports.
REQ-010 Port: hit_align_in  in  NUM_HIT*ALIGN_W  per-channel stretch length in cycles.
REQ-011 Ports: grp_pattern_in  in  NUM_GRP*NUM_HIT  required-hit mask per group; grp_oe_in  in  NUM_GRP  group enable; grp_div_in  in  NUM_GRP*DIV_W  prescale divisor.
REQ-012 Port: trg_match_win_in  in  8  match window length in cycles.
REQ-013 Outputs: coincid_trg_out  1  trigger pulse; coincid_tag_out  NUM_GRP  fired groups; dead_out  1  dead-time flag.
REQ-014 Outputs: hit_syn_out  NUM_HIT, busy_syn_out  NUM_BUSY  conditioned active-high levels; coincid_grp_cnt_out  NUM_GRP*CNT_W  per-group raw match counters.

Function
REQ-015 Each hit line: 2-FF synchroniser, inversion, A/B select, mask; rising edge stretched to max(align,1) cycles; stretched level on hit_syn_out, first high 3 cycles after input falls.
REQ-016 Busy lines: 2-FF sync, inversion, select, mask; busy_any = OR of busy_syn_out.
REQ-017 FSM states IDLE, MATCH, TRIG, DEAD; reset state IDLE.
REQ-018 IDLE: busy_any=0 and any hit_syn_out=1 -> MATCH, window counter loaded with max(trg_match_win_in,1); busy_any=1 holds IDLE.
REQ-019 MATCH: per cycle, group g matches when grp_oe_in[g]=1, pattern nonzero, (hit_syn & pattern)==pattern; matches OR into a sticky tag register.
REQ-020 MATCH: window counter decrements each cycle; at 1 the FSM leaves MATCH next cycle.
REQ-021 On window end, each tagged group increments its prescale counter; group fires when count reaches max(div,1), counter then clears.
REQ-022 Any group fired -> TRIG; none -> IDLE, tag register cleared.
REQ-023 TRIG: coincid_trg_out=1 exactly one cycle, coincid_tag_out = fired groups held until next TRIG; dead counter loaded with DEAD_TIME_NUM; -> DEAD.
REQ-024 DEAD: dead_out=1, hits ignored; exit to IDLE when dead counter=0 and busy_any=0.
REQ-025 Group raw counter increments once per window in which the group tagged, saturating at 2^CNT_W-1, no wrap.
REQ-026 Config inputs are sampled live; changes mid-window take effect next cycle.

Reset
REQ-027 rst_in_N low asynchronously clears all registers: outputs 0, FSM IDLE, counters and prescalers 0.
REQ-028 Reset mid-MATCH or mid-DEAD aborts with no trigger; after release the FSM needs a fresh hit edge.

Configuration
REQ-029 Macro COINCID_TRG_CNT_EN defined: raw counters per REQ-025 present; undefined: counter logic absent, coincid_grp_cnt_out tied 0.

Structure
REQ-030 Package coincid_pkg: FSM state enum, default parameter constants.
REQ-031 Sub-module hit_conditioner: sync, select, mask, edge detect, stretch; instantiated per hit channel.

Verification
REQ-032 Defaults, pattern g0=8'h03, div=1, win=20: ch0,ch1 fall together -> coincid_trg_out pulse 24 cycles later, tag=5'b00001, dead_out 15000 cycles.
REQ-033 grp_div_in g0=2, 4 matching events spaced 20000 cycles -> 2 triggers, raw counter=4.
REQ-034 busy_a_in_N[0] low across dead-time end -> dead_out stays 1 until busy released plus 2 sync cycles.
REQ-035 hit_mask_in[1]=1, same stimulus as REQ-032 -> no trigger, counter 0; hit_ab_sel_in[1]=1 with B side driven -> trigger.
REQ-036 rst_in_N pulsed low mid-window -> outputs 0 immediately, no trigger, next event triggers normally.
